// File: rtl/mult_pkg.sv
// Shared helpers for the tree multiplier. These functions size the carry-save
// reduction tree at elaboration time.
package mult_pkg;

  localparam int MAX_OPS = 32;

  // Rows left after lvl levels of 3:2 compression, starting from n rows.
  function automatic int csa_rows(input int n, input int lvl);
    int r = n;
    for (int i = 0; i < lvl; i++)
      if (r > 2) r = r - r / 3;
    return r;
  endfunction

  // Number of levels needed to reduce n rows down to 2.
  function automatic int csa_levels(input int n);
    int r = n;
    int l = 0;
    while (r > 2) begin
      r = r - r / 3;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor. The carry is pre-shifted, and the top carry-out
// is dropped (modulo 2^WIDTH).
module csa_3to2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
              (x[WIDTH-2:0] & z[WIDTH-2:0]) |
              (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction tree: NUM_OPS operands -> (sum, carry),
// with an optional final carry-propagate add. Backpressure is a global stall.
module csa_tree_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_OPS    = 8,
  parameter int PIPE_EVERY = 1,
  parameter int FINAL_ADD  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] ops_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum_o,
  output logic [WIDTH-1:0]         carry_o,
  output logic [WIDTH-1:0]         res_o
);

  localparam int PE     = (PIPE_EVERY < 1) ? 1 : PIPE_EVERY;
  localparam int LEVELS = csa_levels(NUM_OPS);
  localparam int NSTG   = (LEVELS + PE - 1) / PE;

  if (NUM_OPS < 3 || NUM_OPS > MAX_OPS || PIPE_EVERY < 1) begin : g_bad_param
    $error("csa_tree_pipe: NUM_OPS must be 3..%0d and PIPE_EVERY >= 1", MAX_OPS);
  end

  // vld_pipe[0..NSTG-1] track the tree banks, vld_pipe[NSTG] the output bank
  logic            en;
  logic [NSTG:0]   vld_pipe;

  assign out_valid = vld_pipe[NSTG];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[NSTG-1:0], in_valid};
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI   = csa_rows(NUM_OPS, l);
    localparam int NO   = csa_rows(NUM_OPS, l + 1);
    localparam int NG   = NI / 3;
    localparam bit BANK = ((l + 1) % PE == 0) || (l == LEVELS - 1);

    logic [NI-1:0][WIDTH-1:0] din;
    logic [NO-1:0][WIDTH-1:0] dout;
    logic [NO-1:0][WIDTH-1:0] nxt;

    if (l == 0) begin : g_src
      assign din = ops_i;
    end else begin : g_src
      assign din = g_lvl[l-1].nxt;
    end

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_3to2 #(.WIDTH(WIDTH)) u_csa (
        .x(din[3*g]),
        .y(din[3*g+1]),
        .z(din[3*g+2]),
        .s(dout[2*g]),
        .c(dout[2*g+1])
      );
    end

    // Rows that do not fill a group of three ride through this level untouched
    for (genvar k = 0; k < NI - 3*NG; k++) begin : g_pass
      assign dout[2*NG+k] = din[3*NG+k];
    end

    if (BANK) begin : g_bank
      logic [NO-1:0][WIDTH-1:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (en) q <= dout;
      end
      assign nxt = q;
    end else begin : g_comb
      assign nxt = dout;
    end
  end

  logic [1:0][WIDTH-1:0] last;
  logic [WIDTH-1:0]      res_d;
  logic [WIDTH-1:0]      sum_q, carry_q, res_q;

  assign last = g_lvl[LEVELS-1].nxt;

  // The final adder is combinational into the output bank and does not add a stage
  if (FINAL_ADD != 0) begin : g_fadd
    assign res_d = last[0] + last[1];
  end else begin : g_nofadd
    assign res_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
    end else if (en) begin
      sum_q   <= last[0];
      carry_q <= last[1];
      res_q   <= res_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign res_o   = res_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: table vectors plus stall, bubble, reset and
// parameter-sweep sequences, checked against a queue of expected sums.
module tb_csa_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: 64 bits, 8 ops, bank every level, final add on
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic [7:0][63:0]     ops = '0;
  logic                 in_ready, out_valid;
  logic [63:0]          sum_o, carry_o, res_o;

  csa_tree_pipe #(.WIDTH(64), .NUM_OPS(8), .PIPE_EVERY(1), .FINAL_ADD(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ops_i(ops), .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .carry_o(carry_o), .res_o(res_o));

  // sweep instances, downstream always ready
  logic one = 1'b1;
  logic             v3 = 1'b0, r3, ov3;
  logic [2:0][15:0] ops3 = '0;
  logic [15:0]      s3, c3, x3;
  csa_tree_pipe #(.WIDTH(16), .NUM_OPS(3), .PIPE_EVERY(1), .FINAL_ADD(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .ops_i(ops3),
    .out_valid(ov3), .out_ready(one), .sum_o(s3), .carry_o(c3), .res_o(x3));

  logic              va = 1'b0, ra, ova;
  logic [31:0][31:0] opsa = '0;
  logic [31:0]       sa, ca, xa;
  csa_tree_pipe #(.WIDTH(32), .NUM_OPS(32), .PIPE_EVERY(3), .FINAL_ADD(0)) duta (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .ops_i(opsa),
    .out_valid(ova), .out_ready(one), .sum_o(sa), .carry_o(ca), .res_o(xa));

  logic              vb = 1'b0, rb, ovb;
  logic [31:0][31:0] opsb = '0;
  logic [31:0]       sb, cb, xb;
  csa_tree_pipe #(.WIDTH(32), .NUM_OPS(32), .PIPE_EVERY(2), .FINAL_ADD(1)) dutb (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .ops_i(opsb),
    .out_valid(ovb), .out_ready(one), .sum_o(sb), .carry_o(cb), .res_o(xb));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [7:0][63:0] o);
    logic [63:0] s = '0;
    for (int k = 0; k < 8; k++) s = s + o[k];
    return s;
  endfunction

  // scoreboard and output monitor for the main instance
  logic [63:0] exq[$];
  int          out_cyc[$];
  int          cyc = 0;
  logic [63:0] cur_exp = '0;
  logic        stall_prev = 1'b0;
  logic [63:0] p_sum, p_carry, p_res;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_sum_hold", sum_o, p_sum);
        chk("stall_carry_hold", carry_o, p_carry);
        chk("stall_res_hold", res_o, p_res);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (exq.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          logic [63:0] e;
          e = exq.pop_front();
          chk("res", res_o, e);
          chk("sum_plus_carry", sum_o + carry_o, e);
          chk("carry_bit0", {63'd0, carry_o[0]}, 64'd0);
        end
      end
      stall_prev = out_valid && !out_ready;
      p_sum = sum_o; p_carry = carry_o; p_res = res_o;
      if (in_valid && in_ready) exq.push_back(cur_exp);
    end
  end

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [7:0][63:0] o, input logic [63:0] e);
    logic acc;
    int   n = 0;
    ops = o; cur_exp = e; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exq.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    chk("drain_queue_empty", exq.size(), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic sw_read(input int which, output logic ov, output logic rdy,
                         output logic [63:0] s, output logic [63:0] c, output logic [63:0] r);
    case (which)
      0: begin ov = ov3; rdy = r3; s = {48'd0, s3}; c = {48'd0, c3}; r = {48'd0, x3}; end
      1: begin ov = ova; rdy = ra; s = {32'd0, sa}; c = {32'd0, ca}; r = {32'd0, xa}; end
      default: begin ov = ovb; rdy = rb; s = {32'd0, sb}; c = {32'd0, cb}; r = {32'd0, xb}; end
    endcase
  endtask

  task automatic sweep(input int which, input int lat_exp, input int w, input int nops,
                       input bit fa, input int reps);
    logic [63:0] mask, e, s, c, r;
    logic        ov, rdy;
    int          lat;
    mask = (64'd1 << w) - 64'd1;
    for (int rep = 0; rep < reps; rep++) begin
      e = '0;
      for (int k = 0; k < nops; k++) begin
        logic [63:0] o;
        o = (rep == 0) ? mask : (rnd64() & mask);
        e = e + o;
        case (which)
          0: ops3[k] = o[15:0];
          1: opsa[k] = o[31:0];
          default: opsb[k] = o[31:0];
        endcase
      end
      e = e & mask;
      case (which) 0: v3 = 1'b1; 1: va = 1'b1; default: vb = 1'b1; endcase
      @(negedge clk);
      sw_read(which, ov, rdy, s, c, r);
      chk($sformatf("sweep%0d_ready", which), {63'd0, rdy}, 64'd1);
      @(posedge clk); #1;
      v3 = 1'b0; va = 1'b0; vb = 1'b0;
      lat = 1;
      sw_read(which, ov, rdy, s, c, r);
      while (!ov && lat < 20) begin
        @(posedge clk); #1; lat++;
        sw_read(which, ov, rdy, s, c, r);
      end
      chk($sformatf("sweep%0d_latency", which), lat, lat_exp);
      chk($sformatf("sweep%0d_sum_carry", which), (s + c) & mask, e);
      chk($sformatf("sweep%0d_carry0", which), {63'd0, c[0]}, 64'd0);
      chk($sformatf("sweep%0d_res", which), r, fa ? e : 64'd0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct packed {
    logic [7:0][63:0] ops;
    logic [63:0]      exp;
  } vec_t;
  vec_t tab[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0][63:0] o;

    for (int k = 0; k < 8; k++) begin
      tab[0].ops[k] = 64'(k + 1);
      tab[1].ops[k] = 64'hFFFF_FFFF_FFFF_FFFF;
      tab[2].ops[k] = 64'd0;
      tab[3].ops[k] = 64'h8000_0000_0000_0000;
      tab[4].ops[k] = 64'h5555_5555_5555_5555;
      tab[5].ops[k] = 64'd0;
      tab[6].ops[k] = 64'd1 << (8 * k);
      tab[7].ops[k] = 64'd0;
    end
    tab[5].ops[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tab[5].ops[1] = 64'd1;
    tab[7].ops[0] = 64'h0FED_CBA9_8765_4321;
    tab[7].ops[7] = 64'h1234_5678_9ABC_DEF0;
    tab[0].exp = 64'd36;
    tab[1].exp = 64'hFFFF_FFFF_FFFF_FFF8;
    tab[2].exp = 64'd0;
    tab[3].exp = 64'd0;
    tab[4].exp = 64'hAAAA_AAAA_AAAA_AAA8;
    tab[5].exp = 64'd0;
    tab[6].exp = 64'h0101_0101_0101_0101;
    tab[7].exp = 64'h2222_2222_2222_2211;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", sum_o, 64'd0);
    chk("rst_carry", carry_o, 64'd0);
    chk("rst_res", res_o, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // directed latency with ops 1..8
    send(tab[0].ops, tab[0].exp);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency_8ops", lat, 64'd5);
    drain();

    // table, back to back: one result per cycle
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send(tab[i].ops, tab[i].exp);
    drain();
    chk("table_out_count", out_cyc.size(), 64'd8);
    if (out_cyc.size() == 8) chk("table_throughput", out_cyc[7] - out_cyc[0], 64'd7);

    // bubbles: alternate valid, outputs alternate
    out_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) o[k] = rnd64();
      send(o, model(o));
      @(posedge clk); #1;
    end
    drain();
    chk("bubble_out_count", out_cyc.size(), 64'd6);
    for (int i = 0; i + 1 < out_cyc.size(); i++)
      chk("bubble_spacing", out_cyc[i+1] - out_cyc[i], 64'd2);

    // backpressure: 10 back to back, stall output cycles 3..6
    out_cyc.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0][63:0] ob;
          for (int k = 0; k < 8; k++) ob[k] = rnd64() ^ 64'(i);
          send(ob, model(ob));
        end
      end
      begin
        int g = 0;
        while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          out_ready = !(c >= 3 && c <= 6);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_out_count", out_cyc.size(), 64'd10);

    // reset mid-stream: in-flight bundles vanish
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) o[k] = rnd64();
      send(o, model(o));
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", sum_o, 64'd0);
    chk("midrst_res", res_o, 64'd0);
    exq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_spurious", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    // parameter sweep
    sweep(0, 2, 16, 3, 1'b1, 4);
    sweep(1, 4, 32, 32, 1'b0, 4);
    sweep(2, 5, 32, 32, 1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
